regfile_write_port: RTL and testbench

Write side of the 32x32 MIPS register file. It accepts one register write per cycle and stages it in a one-entry pending register. On the next edge it commits the staged write into the storage array through a 5-to-32 one-hot decoder. It exports the full array to the per-bit 32:1 read-mux trees, plus forwarding data for the two read ports while a write is still pending.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_write_port_dec_onehot.sv | 13 +
 rtl/regfile_write_port.sv | 72 +++++++
 tb/tb_regfile_write_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the 32x32 register file write side.
package regfile_pkg;
  localparam int NREG  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 16;

  typedef logic [AW-1:0]          reg_addr_t;
  typedef logic [WIDTH-1:0]       reg_data_t;
  typedef reg_data_t [NREG-1:0]   reg_array_t;
endpackage

// File: rtl/regfile_write_port_dec_onehot.sv
// AW-to-NREG one-hot decoder; output is all zeros when en is low.
module dec_onehot
  import regfile_pkg::*;
(
  input  logic            en,
  input  reg_addr_t       a,
  output logic [NREG-1:0] oh
);
  always_comb begin
    oh = '0;
    if (en) oh[a] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_port.sv
// Register file write side: one-entry staging register, one-hot commit into
// the storage array, and forwarding of the staged write to both read ports.
module regfile_write_port
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  reg_addr_t       wa_i,
  input  reg_data_t       wd_i,
  input  reg_addr_t       ra1_i,
  input  reg_addr_t       ra2_i,
  output reg_array_t      regs_o,
  output logic            pend_v_o,
  output reg_addr_t       pend_a_o,
  output logic            fwd1_v_o,
  output reg_data_t       fwd1_d_o,
  output logic            fwd2_v_o,
  output reg_data_t       fwd2_d_o,
  output logic [CW-1:0]   commit_cnt_o
);
  // Interface: no back-pressure. A write offered with we_i is accepted on the
  // same edge; there is no ready signal because the block never stalls.
  logic            pend_v;
  reg_addr_t       pend_a;
  reg_data_t       pend_d;
  logic [NREG-1:0] row_en;
  reg_array_t      regs_q;
  logic [CW-1:0]   cnt_q;
  logic            capture;

  assign capture = we_i && (wa_i != '0);

  dec_onehot u_dec (
    .en (pend_v),
    .a  (pend_a),
    .oh (row_en)
  );

  // Row 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v <= 1'b0;
      pend_a <= '0;
      pend_d <= '0;
      cnt_q  <= '0;
      regs_q <= '0;
    end else begin
      pend_v <= capture;
      if (capture) begin
        pend_a <= wa_i;
        pend_d <= wd_i;
      end
      if (pend_v && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      for (int r = 1; r < NREG; r++) begin
        if (row_en[r]) regs_q[r] <= pend_d;
      end
    end
  end

  always_comb begin
    fwd1_v_o = pend_v && (pend_a == ra1_i) && (ra1_i != '0);
    fwd2_v_o = pend_v && (pend_a == ra2_i) && (ra2_i != '0);
    fwd1_d_o = fwd1_v_o ? pend_d : '0;
    fwd2_d_o = fwd2_v_o ? pend_d : '0;
  end

  assign regs_o       = regs_q;
  assign pend_v_o     = pend_v;
  assign pend_a_o     = pend_a;
  assign commit_cnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboarded random and directed bench for regfile_write_port.
module tb_regfile_write_port;
  import regfile_pkg::*;

  localparam int QW = 32 + AW + WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we_i;
  reg_addr_t     wa_i, ra1_i, ra2_i;
  reg_data_t     wd_i;
  reg_array_t    regs_o;
  logic          pend_v_o, fwd1_v_o, fwd2_v_o;
  reg_addr_t     pend_a_o;
  reg_data_t     fwd1_d_o, fwd2_d_o;
  logic [CW-1:0] commit_cnt_o;

  regfile_write_port dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .wa_i(wa_i), .wd_i(wd_i),
    .ra1_i(ra1_i), .ra2_i(ra2_i), .regs_o(regs_o),
    .pend_v_o(pend_v_o), .pend_a_o(pend_a_o),
    .fwd1_v_o(fwd1_v_o), .fwd1_d_o(fwd1_d_o),
    .fwd2_v_o(fwd2_v_o), .fwd2_d_o(fwd2_d_o),
    .commit_cnt_o(commit_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [QW-1:0] exp_q[$];
  reg_array_t    ref_regs;
  int            ref_cnt;
  reg_addr_t     last_a;
  logic          checking = 1'b0;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                       input reg_addr_t r1, input reg_addr_t r2);
    we_i = we; wa_i = wa; wd_i = wd; ra1_i = r1; ra2_i = r2;
    if (we && wa != '0) exp_q.push_back({cyc, wa, wd});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [QW-1:0] ent;
  logic [31:0]   e_cyc;
  reg_addr_t     e_a;
  reg_data_t     e_d;
  logic          e1_v, e2_v;

  always @(negedge clk) begin
    if (checking) begin
      n_checks++;
      if (regs_o !== ref_regs) begin
        n_fail++;
        for (int r = 0; r < NREG; r++) begin
          if (regs_o[r] !== ref_regs[r]) begin
            $display("FAIL regs cycle %0d: row %0d got 0x%0h expected 0x%0h",
                     cyc, r, regs_o[r], ref_regs[r]);
            break;
          end
        end
      end
      chk("commit_cnt", 64'(commit_cnt_o), 64'(ref_cnt));

      if (pend_v_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pend_v_unexpected", 64'(pend_v_o), 64'd0);
        end else begin
          ent = exp_q.pop_front();
          {e_cyc, e_a, e_d} = ent;
          chk("pend_latency", 64'(cyc - e_cyc), 64'd1);
          chk("pend_a", 64'(pend_a_o), 64'(e_a));
          e1_v = (ra1_i == e_a) && (ra1_i != '0);
          e2_v = (ra2_i == e_a) && (ra2_i != '0);
          chk("fwd1_v", 64'(fwd1_v_o), 64'(e1_v));
          chk("fwd1_d", 64'(fwd1_d_o), e1_v ? 64'(e_d) : 64'd0);
          chk("fwd2_v", 64'(fwd2_v_o), 64'(e2_v));
          chk("fwd2_d", 64'(fwd2_d_o), e2_v ? 64'(e_d) : 64'd0);
          last_a = e_a;
          // This write lands in the array at the coming edge unless reset wins.
          if (rst_n) begin
            ref_regs[e_a] = e_d;
            if (ref_cnt < 65535) ref_cnt = ref_cnt + 1;
          end
        end
      end else begin
        // Anything still queued must have been issued this very cycle.
        if (exp_q.size() != 0) begin
          ent = exp_q[0];
          chk("pend_missing", 64'(ent[QW-1 -: 32]), 64'(cyc));
        end
        chk("pend_a_hold", 64'(pend_a_o), 64'(last_a));
        chk("fwd1_v_idle", 64'(fwd1_v_o), 64'd0);
        chk("fwd1_d_idle", 64'(fwd1_d_o), 64'd0);
        chk("fwd2_v_idle", 64'(fwd2_v_o), 64'd0);
        chk("fwd2_d_idle", 64'(fwd2_d_o), 64'd0);
      end

      if (!rst_n) begin
        ref_regs = '0;
        ref_cnt  = 0;
        last_a   = '0;
        exp_q.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  reg_addr_t a, r1, last_w;
  initial begin
    ref_regs = '0; ref_cnt = 0; last_a = '0; last_w = 5'd1;
    we_i = 1'b0; wa_i = '0; wd_i = '0; ra1_i = '0; ra2_i = '0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    checking = 1'b1;

    // Basic write to r5
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    idle(2);
    // r0 writes are dropped
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(2);
    // Forwarding: r7 pending while ra1 = 7, ra2 = 3
    drive(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
    // Back-to-back same address, last write wins
    drive(1'b1, 5'd9, 32'h1, 5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h2, 5'd9, 5'd9);
    idle(2);
    // Reset while a write is pending
    drive(1'b1, 5'd4, 32'hAA, 5'd4, 5'd0);
    do_reset();
    idle(2);

    // Random traffic, reads biased toward the most recent write
    for (int i = 0; i < 400; i++) begin
      a  = 5'($urandom_range(0, NREG - 1));
      r1 = ($urandom_range(0, 1) == 1) ? last_w : 5'($urandom_range(0, NREG - 1));
      drive($urandom_range(0, 4) != 0, a, $urandom, r1,
            ($urandom_range(0, 1) == 1) ? last_w : 5'($urandom_range(0, NREG - 1)));
      last_w = a;
    end
    idle(2);

    // Long sustained run: pushes the commit counter into saturation
    for (int i = 0; i < 65540; i++) begin
      a = 5'((i % 31) + 1);
      drive(1'b1, a, $urandom, a, 5'($urandom_range(0, NREG - 1)));
    end
    idle(3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("cnt_saturated", 64'(commit_cnt_o), 64'hFFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
